// File: rtl/sobel_gradient_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_gradient_unit_if
//  Description : Handshake/data bundle between the edge-detect controller
//                (master) and the Sobel gradient datapath (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sobel_gradient_unit_if #(
  parameter int PIX_W = 8
) ();
  localparam int MAG_W = PIX_W + 3;

  logic [PIX_W-1:0] pixel_in;
  logic             pixel_load;
  logic             shift_col;
  logic             shift_row;
  logic             start_calculation;
  logic [MAG_W-1:0] threshold;
  logic             window_full;
  logic             busy;
  logic             calculation_done;
  logic             edge_out;
  logic [PIX_W-1:0] mag_out;

  modport master (
    output pixel_in, pixel_load, shift_col, shift_row, start_calculation, threshold,
    input  window_full, busy, calculation_done, edge_out, mag_out
  );

  modport slave (
    input  pixel_in, pixel_load, shift_col, shift_row, start_calculation, threshold,
    output window_full, busy, calculation_done, edge_out, mag_out
  );
endinterface
`default_nettype wire

// File: rtl/sobel_gradient_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_gradient_unit
//  Description : 3x3 Sobel window with column/row sliding and a multi-cycle
//                |Gx|+|Gy| magnitude + threshold computation.
//                Optional macro SOBEL_MAG_CLAMP_EN: mag_out saturates at
//                2^PIX_W-1 instead of being the magnitude divided by 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_gradient_unit #(
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sobel_gradient_unit_if.slave  bus
);
  localparam int MAG_W = PIX_W + 3;
  localparam logic [1:0] c_ORD_FULL = 2'd0;
  localparam logic [1:0] c_ORD_COL  = 2'd1;
  localparam logic [1:0] c_ORD_ROW  = 2'd2;
  localparam logic [MAG_W:0] c_PIX_MAX = (MAG_W+1)'((1 << PIX_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRAD   = 3'd1,
    S_MAG    = 3'd2,
    S_THRESH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  r_state;
  logic [PIX_W-1:0]        r_win [0:8];   // p1..p9, row-major
  logic [3:0]              r_pend;
  logic [1:0]              r_order;
  logic                    r_full;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_edge;
  logic [PIX_W-1:0]        r_mag_out;
  logic [MAG_W-1:0]        r_thr;
  logic signed [MAG_W:0]   r_gx;
  logic signed [MAG_W:0]   r_gy;
  logic [MAG_W:0]          r_mag;         // top bit always zero (max 2040)

  logic [3:0]              w_slot;
  logic signed [MAG_W:0]   w_gx;
  logic signed [MAG_W:0]   w_gy;
  logic [MAG_W:0]          w_ax;
  logic [MAG_W:0]          w_ay;
  logic [PIX_W-1:0]        w_scaled;

  function automatic logic signed [MAG_W:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(MAG_W+1-PIX_W){1'b0}}, p});
  endfunction

  // Next window slot to write: column order fills p3,p6,p9; full and row
  // orders both map to index 9-pending (row order only runs pending 3..1).
  always_comb begin
    w_slot = 4'd9 - r_pend;
    if (r_order == c_ORD_COL) begin
      w_slot = 4'd11 - (r_pend + r_pend + r_pend);
    end
  end

  // Gradient, absolute values and output scaling.
  always_comb begin
    w_gx = (ext(r_win[2]) + ext(r_win[5]) + ext(r_win[5]) + ext(r_win[8]))
         - (ext(r_win[0]) + ext(r_win[3]) + ext(r_win[3]) + ext(r_win[6]));
    w_gy = (ext(r_win[6]) + ext(r_win[7]) + ext(r_win[7]) + ext(r_win[8]))
         - (ext(r_win[0]) + ext(r_win[1]) + ext(r_win[1]) + ext(r_win[2]));
    w_ax = r_gx[MAG_W] ? $unsigned(-r_gx) : $unsigned(r_gx);
    w_ay = r_gy[MAG_W] ? $unsigned(-r_gy) : $unsigned(r_gy);
`ifdef SOBEL_MAG_CLAMP_EN
    w_scaled = (r_mag > c_PIX_MAX) ? {PIX_W{1'b1}} : r_mag[PIX_W-1:0];
`else
    w_scaled = r_mag[MAG_W-1:3];
`endif
  end

  // Control FSM plus window storage; inputs only act in IDLE.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      r_pend    <= 4'd9;
      r_order   <= c_ORD_FULL;
      r_full    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_edge    <= 1'b0;
      r_mag_out <= '0;
      r_thr     <= '0;
      r_gx      <= '0;
      r_gy      <= '0;
      r_mag     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_calculation && r_full) begin
            r_thr   <= bus.threshold;
            r_busy  <= 1'b1;
            r_state <= S_GRAD;
          end else if (bus.shift_row) begin
            for (int i = 0; i < 6; i++) r_win[i] <= r_win[i+3];
            r_pend  <= 4'd3;
            r_order <= c_ORD_ROW;
            r_full  <= 1'b0;
          end else if (bus.shift_col) begin
            for (int r = 0; r < 3; r++) begin
              r_win[3*r]   <= r_win[3*r+1];
              r_win[3*r+1] <= r_win[3*r+2];
            end
            r_pend  <= 4'd3;
            r_order <= c_ORD_COL;
            r_full  <= 1'b0;
          end else if (bus.pixel_load && (r_pend != 4'd0)) begin
            r_win[w_slot] <= bus.pixel_in;
            r_pend        <= r_pend - 4'd1;
            r_full        <= (r_pend == 4'd1);
          end
        end
        S_GRAD: begin
          r_gx    <= w_gx;
          r_gy    <= w_gy;
          r_state <= S_MAG;
        end
        S_MAG: begin
          r_mag   <= w_ax + w_ay;
          r_state <= S_THRESH;
        end
        S_THRESH: begin
          r_edge    <= (r_mag > {1'b0, r_thr});
          r_mag_out <= w_scaled;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.window_full      = r_full;
  assign bus.busy             = r_busy;
  assign bus.calculation_done = r_done;
  assign bus.edge_out         = r_edge;
  assign bus.mag_out          = r_mag_out;
endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_gradient_unit
//  Description : Directed self-checking bench for sobel_gradient_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_gradient_unit;
  localparam int PIX_W = 8;

  logic clk;
  logic n_rst;
  int   n_err;
  int   n_chk;

  sobel_gradient_unit_if #(.PIX_W(PIX_W)) sob_if ();

  sobel_gradient_unit #(.PIX_W(PIX_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (sob_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SOBEL_MAG_CLAMP_EN
  localparam int c_EXP_A = 255;
  localparam int c_EXP_B = 255;
  localparam int c_EXP_C = 255;
`else
  localparam int c_EXP_A = 127;   // 1020 >> 3
  localparam int c_EXP_B = 89;    // 712 >> 3
  localparam int c_EXP_C = 172;   // 1376 >> 3
`endif

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p);
    sob_if.pixel_in   = p[PIX_W-1:0];
    sob_if.pixel_load = 1'b1;
    tick();
    sob_if.pixel_load = 1'b0;
  endtask

  // Waits for the done pulse; n counts cycles since start was sampled.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!sob_if.calculation_done && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic start(input int thr);
    sob_if.threshold         = thr[PIX_W+2:0];
    sob_if.start_calculation = 1'b1;
    tick();
    sob_if.start_calculation = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    int row_pat [9];
    n_err = 0;
    n_chk = 0;
    n_rst = 1'b0;
    sob_if.pixel_in = '0;
    sob_if.pixel_load = 1'b0;
    sob_if.shift_col = 1'b0;
    sob_if.shift_row = 1'b0;
    sob_if.start_calculation = 1'b0;
    sob_if.threshold = '0;
    tick();
    tick();
    check("rst_full", int'(sob_if.window_full), 0);
    check("rst_busy", int'(sob_if.busy), 0);
    check("rst_done", int'(sob_if.calculation_done), 0);
    check("rst_edge", int'(sob_if.edge_out), 0);
    check("rst_mag",  int'(sob_if.mag_out), 0);
    n_rst = 1'b1;
    tick();

    // Flat window: zero gradient.
    for (int i = 0; i < 8; i++) load(10);
    check("full_after8", int'(sob_if.window_full), 0);
    load(10);
    check("full_after9", int'(sob_if.window_full), 1);
    start(0);
    check("flat_busy", int'(sob_if.busy), 1);
    wait_done(1, n);
    check("flat_latency", n, 4);
    check("flat_edge", int'(sob_if.edge_out), 0);
    check("flat_mag",  int'(sob_if.mag_out), 0);
    tick();
    check("flat_done_pulse", int'(sob_if.calculation_done), 0);
    check("flat_busy_end", int'(sob_if.busy), 0);

    // Columns 0/77/255: Gx=1020, Gy=0.
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    row_pat = '{0, 77, 255, 0, 77, 255, 0, 77, 255};
    foreach (row_pat[i]) load(row_pat[i]);
    start(100);
    wait_done(1, n);
    check("ramp_latency", n, 4);
    check("ramp_edge", int'(sob_if.edge_out), 1);
    check("ramp_mag",  int'(sob_if.mag_out), c_EXP_A);
    tick();

    // shift_col then new column 255: cols 77/255/255 -> Gx=712, Gy=0.
    sob_if.shift_col = 1'b1;
    tick();
    sob_if.shift_col = 1'b0;
    check("scol_full0", int'(sob_if.window_full), 0);
    load(255);
    load(255);
    check("scol_full2", int'(sob_if.window_full), 0);
    load(255);
    check("scol_full3", int'(sob_if.window_full), 1);
    start(700);
    wait_done(1, n);
    check("scol_edge", int'(sob_if.edge_out), 1);
    check("scol_mag",  int'(sob_if.mag_out), c_EXP_B);
    tick();

    // shift_row then start with window not full: must be ignored.
    sob_if.shift_row = 1'b1;
    tick();
    sob_if.shift_row = 1'b0;
    sob_if.start_calculation = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sob_if.busy || sob_if.calculation_done) seen = 1;
    end
    sob_if.start_calculation = 1'b0;
    check("nofull_ignored", seen, 0);
    check("nofull_full", int'(sob_if.window_full), 0);
    // Row 3 becomes zeros: Gx=534, Gy=-842, mag=1376; equal threshold -> no edge.
    load(0);
    load(0);
    load(0);
    check("srow_full", int'(sob_if.window_full), 1);
    start(1376);
    wait_done(1, n);
    check("srow_latency", n, 4);
    check("srow_edge_eq", int'(sob_if.edge_out), 0);
    check("srow_mag", int'(sob_if.mag_out), c_EXP_C);
    tick();

    // start beats shift_row; loads/shifts while busy are ignored.
    sob_if.threshold = 11'd1375;
    sob_if.start_calculation = 1'b1;
    sob_if.shift_row = 1'b1;
    tick();
    sob_if.start_calculation = 1'b0;
    sob_if.shift_row = 1'b0;
    sob_if.shift_col = 1'b1;
    sob_if.pixel_load = 1'b1;
    sob_if.pixel_in = 8'd200;
    tick();
    sob_if.shift_col = 1'b0;
    sob_if.pixel_load = 1'b0;
    wait_done(2, n);
    check("busy_latency", n, 4);
    check("busy_edge", int'(sob_if.edge_out), 1);
    check("busy_mag", int'(sob_if.mag_out), c_EXP_C);
    tick();
    check("busy_full_kept", int'(sob_if.window_full), 1);
    start(1375);
    wait_done(1, n);
    check("recompute_mag", int'(sob_if.mag_out), c_EXP_C);
    tick();

    // Reset while in MAG aborts without a done pulse.
    start(0);          // now in GRAD
    tick();            // now in MAG
    n_rst = 1'b0;
    tick();
    check("abort_busy", int'(sob_if.busy), 0);
    check("abort_done", int'(sob_if.calculation_done), 0);
    check("abort_edge", int'(sob_if.edge_out), 0);
    check("abort_mag",  int'(sob_if.mag_out), 0);
    check("abort_full", int'(sob_if.window_full), 0);
    n_rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sob_if.calculation_done || sob_if.busy) seen = 1;
    end
    check("abort_no_pulse", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
